// File: rtl/range_sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : range_sensor_pkg
// Description : Shared types and constants for the range-sensor scheduler:
//               scheduler state encoding, default timeout and guard widths,
//               and the channel-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package range_sensor_pkg;

   // Scheduler FSM states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SELECT    = 3'd1,
      TRIGGER   = 3'd2,
      WAIT_DONE = 3'd3,
      GUARD     = 3'd4
   } sched_state_t;

   // 40 ms at 100 MHz
   localparam int TIMEOUT_CYCLES_DEF = 4000000;
   localparam int GUARD_W_DEF        = 24;

   // Width of a channel index for n channels
   function automatic int ch_idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/range_sensor_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : range_sensor_scheduler_if
// Description : Control / channel bus of the range-sensor scheduler. The
//               master side issues scan controls and returns per-channel
//               completion pulses; the slave side is the scheduler itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface range_sensor_scheduler_if
   import range_sensor_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int GUARD_W = GUARD_W_DEF
);
   localparam int c_idx_w = ch_idx_w(N_CH);

   logic                start_i;
   logic                cont_en_i;
   logic                abort_i;
   logic [N_CH-1:0]     chan_en_i;
   logic [GUARD_W-1:0]  guard_cycles_i;
   logic [N_CH-1:0]     done_i;
   logic [N_CH-1:0]     tick_o;
   logic [c_idx_w-1:0]  active_ch_o;
   logic                busy_o;
   logic                timeout_o;
   logic                scan_done_o;
   logic [7:0]          tmo_cnt_o;

   modport master (
      output start_i, cont_en_i, abort_i, chan_en_i, guard_cycles_i, done_i,
      input  tick_o, active_ch_o, busy_o, timeout_o, scan_done_o, tmo_cnt_o
   );

   modport slave (
      input  start_i, cont_en_i, abort_i, chan_en_i, guard_cycles_i, done_i,
      output tick_o, active_ch_o, busy_o, timeout_o, scan_done_o, tmo_cnt_o
   );

endinterface
`default_nettype wire

// File: rtl/range_sensor_ch_select.sv
`default_nettype none
// ============================================================================
// Module      : range_sensor_ch_select
// Description : Combinational priority finder. Returns the lowest enabled
//               channel index that is greater than or equal to the pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module range_sensor_ch_select
   import range_sensor_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int IDX_W = 2
) (
   input  wire logic [N_CH-1:0]  i_chan_en,
   input  wire logic [IDX_W:0]   i_ptr,
   output logic                  o_found,
   output logic [IDX_W-1:0]      o_idx
);

   // Scan from the top down so the lowest qualifying index is written last
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (i_chan_en[i] && (i >= int'(i_ptr))) begin
            o_found = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/range_sensor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : range_sensor_scheduler
// Description : Fires up to N_CH ultrasonic range-sensor channels one at a
//               time, waits for each completion (or a timeout), then holds a
//               programmable guard interval before moving on. Supports
//               single-scan and continuous scanning with abort.
//               Optional macro RANGE_SCHED_TMO_STATS_EN enables a saturating
//               8-bit timeout statistics counter on tmo_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module range_sensor_scheduler
   import range_sensor_pkg::*;
#(
   parameter int N_CH           = 4,
   parameter int GUARD_W        = GUARD_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  wire logic clk_i,
   input  wire logic rst_i,
   range_sensor_scheduler_if.slave bus
);

   localparam int c_idx_w = ch_idx_w(N_CH);
   localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

   sched_state_t          r_state;
   logic [c_idx_w:0]      r_ptr;        // one bit wider so it can reach N_CH
   logic                  r_visited;
   logic [c_idx_w-1:0]    r_active;
   logic [N_CH-1:0]       r_tick;
   logic                  r_timeout;
   logic                  r_scan_done;
   logic [c_tmo_w-1:0]    r_tmo_cnt;
   logic [GUARD_W-1:0]    r_guard;

   logic                  w_found;
   logic [c_idx_w-1:0]    w_idx;
   logic                  w_done_act;
   logic                  w_tmo_hit;
   logic                  w_abort;
   logic [GUARD_W-1:0]    w_guard_load;

   range_sensor_ch_select #(
      .N_CH  (N_CH),
      .IDX_W (c_idx_w)
   ) u_ch_select (
      .i_chan_en (bus.chan_en_i),
      .i_ptr     (r_ptr),
      .o_found   (w_found),
      .o_idx     (w_idx)
   );

   assign w_done_act   = bus.done_i[r_active];
   assign w_abort      = (r_state != IDLE) && bus.abort_i;
   // Completion takes precedence over a coincident timeout
   assign w_tmo_hit    = (r_state == WAIT_DONE) && !w_abort && !w_done_act &&
                         (r_tmo_cnt == c_tmo_last);
   // A zero guard setting still spends one cycle in GUARD
   assign w_guard_load = (bus.guard_cycles_i == '0) ? GUARD_W'(1) : bus.guard_cycles_i;

   // Scheduler FSM with registered pulse outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_visited   <= 1'b0;
         r_active    <= '0;
         r_tick      <= '0;
         r_timeout   <= 1'b0;
         r_scan_done <= 1'b0;
         r_tmo_cnt   <= '0;
         r_guard     <= '0;
      end else begin
         r_tick      <= '0;
         r_timeout   <= 1'b0;
         r_scan_done <= 1'b0;
         if (w_abort) begin
            r_state <= IDLE;
            r_ptr   <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (bus.start_i || bus.cont_en_i) begin
                     r_state   <= SELECT;
                     r_ptr     <= '0;
                     r_visited <= 1'b0;
                  end
               end
               SELECT: begin
                  if (w_found) begin
                     r_active  <= w_idx;
                     r_tick    <= N_CH'(1) << w_idx;
                     r_tmo_cnt <= '0;
                     r_state   <= TRIGGER;
                  end else if (r_visited) begin
                     // End of a non-empty scan; continuous mode rescans
                     r_scan_done <= 1'b1;
                     r_visited   <= 1'b0;
                     r_ptr       <= '0;
                     r_state     <= bus.cont_en_i ? SELECT : IDLE;
                  end else begin
                     r_ptr   <= '0;
                     r_state <= IDLE;
                  end
               end
               TRIGGER: begin
                  // The request cycle counts toward the timeout window
                  r_visited <= 1'b1;
                  r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
                  r_state   <= WAIT_DONE;
               end
               WAIT_DONE: begin
                  if (w_done_act) begin
                     r_guard <= w_guard_load;
                     r_state <= GUARD;
                  end else if (w_tmo_hit) begin
                     r_timeout <= 1'b1;
                     r_guard   <= w_guard_load;
                     r_state   <= GUARD;
                  end else begin
                     r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
                  end
               end
               GUARD: begin
                  if (r_guard <= GUARD_W'(1)) begin
                     r_ptr   <= (c_idx_w + 1)'(r_active) + (c_idx_w + 1)'(1);
                     r_state <= SELECT;
                  end else begin
                     r_guard <= r_guard - GUARD_W'(1);
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_ptr   <= '0;
               end
            endcase
         end
      end
   end

`ifdef RANGE_SCHED_TMO_STATS_EN
   logic [7:0] r_tmo_stat;

   // Saturating timeout tally, cleared when a new single scan is accepted
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tmo_stat <= 8'd0;
      end else if ((r_state == IDLE) && bus.start_i) begin
         r_tmo_stat <= 8'd0;
      end else if (w_tmo_hit && (r_tmo_stat != 8'hFF)) begin
         r_tmo_stat <= r_tmo_stat + 8'd1;
      end
   end

   assign bus.tmo_cnt_o = r_tmo_stat;
`else
   assign bus.tmo_cnt_o = 8'd0;
`endif

   assign bus.tick_o      = r_tick;
   assign bus.active_ch_o = r_active;
   assign bus.busy_o      = (r_state != IDLE);
   assign bus.timeout_o   = r_timeout;
   assign bus.scan_done_o = r_scan_done;

endmodule
`default_nettype wire

// File: tb/tb_range_sensor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_range_sensor_scheduler
// Description : Directed self-checking bench for range_sensor_scheduler with
//               N_CH=4, TIMEOUT_CYCLES=100.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_range_sensor_scheduler;

   localparam int N_CH    = 4;
   localparam int GUARD_W = 24;
   localparam int TMO     = 100;
`ifdef RANGE_SCHED_TMO_STATS_EN
   localparam int EXP_TMO1 = 1;
`else
   localparam int EXP_TMO1 = 0;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   range_sensor_scheduler_if #(.N_CH(N_CH), .GUARD_W(GUARD_W)) bus ();

   range_sensor_scheduler #(
      .N_CH           (N_CH),
      .GUARD_W        (GUARD_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;
   int tq_val[$];
   int tq_cyc[$];
   int tmo_q[$];
   int sd_q[$];
   int sc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic clear_log();
      tq_val.delete();
      tq_cyc.delete();
      tmo_q.delete();
      sd_q.delete();
   endtask

   task automatic pulse_start();
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      sc = cyc;
   endtask

   // Runs until busy drops; answers each tick with done after dly cycles
   task automatic run_scan(input int dly, input int clr_tick, input int abort_ofs, input int budget);
      int due    = -1;
      int clr_at = -1;
      int ab_at  = -1;
      logic [N_CH-1:0] pend = '0;
      for (int n = 0; n < budget; n++) begin
         step();
         bus.done_i  = (cyc == due) ? pend : '0;
         bus.abort_i = (ab_at >= 0) && (cyc == ab_at);
         if (cyc == clr_at) bus.cont_en_i = 1'b0;
         if (bus.tick_o != '0) begin
            tq_val.push_back(int'(bus.tick_o));
            tq_cyc.push_back(cyc);
            if (dly > 0) begin
               due  = cyc + dly;
               pend = bus.tick_o;
            end
            if ((clr_tick != 0) && (int'(bus.tick_o) == clr_tick)) clr_at = cyc + 2;
            if ((abort_ofs > 0) && (ab_at < 0)) ab_at = cyc + abort_ofs;
         end
         if (bus.timeout_o)   tmo_q.push_back(cyc);
         if (bus.scan_done_o) sd_q.push_back(cyc);
         if (!bus.busy_o) break;
      end
      bus.done_i  = '0;
      bus.abort_i = 1'b0;
      check_eq("run_ends_idle", 32'(bus.busy_o), 0);
   endtask

   task automatic idle_window(input string tag, input int n);
      int ticks = 0;
      int busy  = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (bus.tick_o != '0) ticks++;
         if (bus.busy_o) busy++;
      end
      check_eq({tag, "_no_ticks"}, ticks, 0);
      check_eq({tag, "_no_busy"}, busy, 0);
   endtask

   initial begin
      bus.start_i        = 1'b0;
      bus.cont_en_i      = 1'b0;
      bus.abort_i        = 1'b0;
      bus.chan_en_i      = '0;
      bus.guard_cycles_i = '0;
      bus.done_i         = '0;

      // Reset state
      repeat (3) step();
      check_eq("rst_tick", 32'(bus.tick_o), 0);
      check_eq("rst_busy", 32'(bus.busy_o), 0);
      check_eq("rst_active", 32'(bus.active_ch_o), 0);
      check_eq("rst_timeout", 32'(bus.timeout_o), 0);
      check_eq("rst_scan_done", 32'(bus.scan_done_o), 0);
      check_eq("rst_tmo_cnt", 32'(bus.tmo_cnt_o), 0);
      rst_i = 1'b0;
      step();

      // 1: mask 1011, guard 10, done 5 cycles after each tick
      bus.chan_en_i      = 4'b1011;
      bus.guard_cycles_i = 24'd10;
      clear_log();
      pulse_start();
      check_eq("t1_busy_after_start", 32'(bus.busy_o), 1);
      run_scan(5, 0, 0, 200);
      check_eq("t1_tick_count", tq_val.size(), 3);
      if (tq_val.size() == 3) begin
         check_eq("t1_latency", tq_cyc[0] - sc, 1);
         check_eq("t1_tick0", tq_val[0], 1);
         check_eq("t1_tick1", tq_val[1], 2);
         check_eq("t1_tick2", tq_val[2], 8);
         check_eq("t1_spacing01", tq_cyc[1] - tq_cyc[0], 17);
         check_eq("t1_spacing12", tq_cyc[2] - tq_cyc[1], 17);
         check_eq("t1_scan_done_count", sd_q.size(), 1);
         if (sd_q.size() == 1) check_eq("t1_scan_done_pos", sd_q[0] - tq_cyc[2], 17);
      end
      check_eq("t1_active_hold", 32'(bus.active_ch_o), 3);
      check_eq("t1_no_timeout", tmo_q.size(), 0);

      // 2: single channel never answers -> timeout
      bus.chan_en_i = 4'b0100;
      clear_log();
      pulse_start();
      run_scan(0, 0, 0, 400);
      check_eq("t2_tick_count", tq_val.size(), 1);
      check_eq("t2_timeout_count", tmo_q.size(), 1);
      if ((tq_val.size() == 1) && (tmo_q.size() == 1)) begin
         check_eq("t2_tick_val", tq_val[0], 4);
         check_eq("t2_timeout_pos", tmo_q[0] - tq_cyc[0], 100);
      end
      check_eq("t2_scan_done_count", sd_q.size(), 1);
      if ((sd_q.size() == 1) && (tq_cyc.size() == 1))
         check_eq("t2_scan_done_pos", sd_q[0] - tq_cyc[0], 111);
      check_eq("t2_tmo_cnt", 32'(bus.tmo_cnt_o), EXP_TMO1);

      // 3: empty mask
      bus.chan_en_i = 4'b0000;
      clear_log();
      pulse_start();
      check_eq("t3_busy_high", 32'(bus.busy_o), 1);
      run_scan(0, 0, 0, 10);
      check_eq("t3_busy_len", cyc - sc, 1);
      check_eq("t3_no_ticks", tq_val.size(), 0);
      check_eq("t3_no_scan_done", sd_q.size(), 0);

      // 4: continuous mode cleared during second channel's wait
      bus.chan_en_i = 4'b0011;
      clear_log();
      bus.cont_en_i = 1'b1;
      run_scan(5, 2, 0, 300);
      check_eq("t4_tick_count", tq_val.size(), 2);
      if (tq_val.size() == 2) begin
         check_eq("t4_tick0", tq_val[0], 1);
         check_eq("t4_tick1", tq_val[1], 2);
      end
      check_eq("t4_scan_done_count", sd_q.size(), 1);
      idle_window("t4", 30);

      // 5: abort during guard of channel 0, then restart
      bus.chan_en_i = 4'b1011;
      clear_log();
      pulse_start();
      run_scan(5, 0, 8, 200);
      check_eq("t5_tick_count", tq_val.size(), 1);
      if (tq_val.size() == 1) check_eq("t5_idle_pos", cyc - tq_cyc[0], 9);
      check_eq("t5_no_scan_done", sd_q.size(), 0);
      idle_window("t5", 30);
      clear_log();
      pulse_start();
      check_eq("t5_tmo_cnt_cleared", 32'(bus.tmo_cnt_o), 0);
      run_scan(5, 0, 0, 200);
      check_eq("t5_restart_count", tq_val.size(), 3);
      if (tq_val.size() > 0) check_eq("t5_restart_ch0", tq_val[0], 1);

      // 6: asynchronous reset mid WAIT_DONE
      bus.chan_en_i = 4'b0010;
      clear_log();
      pulse_start();
      step();
      check_eq("t6_tick", 32'(bus.tick_o), 2);
      step();
      step();
      check_eq("t6_busy_before", 32'(bus.busy_o), 1);
      check_eq("t6_active_before", 32'(bus.active_ch_o), 1);
      #3 rst_i = 1'b1;
      #1;
      check_eq("t6_async_busy", 32'(bus.busy_o), 0);
      check_eq("t6_async_active", 32'(bus.active_ch_o), 0);
      check_eq("t6_async_tick", 32'(bus.tick_o), 0);
      #1 rst_i = 1'b0;
      idle_window("t6", 10);

      // done arriving on the last timeout cycle wins
      bus.chan_en_i      = 4'b0001;
      bus.guard_cycles_i = 24'd3;
      clear_log();
      pulse_start();
      run_scan(99, 0, 0, 300);
      check_eq("t6_done_wins_no_timeout", tmo_q.size(), 0);
      check_eq("t6_done_wins_ticks", tq_val.size(), 1);
      check_eq("t6_done_wins_scan_done", sd_q.size(), 1);
      if ((sd_q.size() == 1) && (tq_cyc.size() == 1))
         check_eq("t6_done_wins_sd_pos", sd_q[0] - tq_cyc[0], 104);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
`default_nettype wire
